// File: rtl/mio_bus_responder.sv
// Wait-state memory responder for the CPU_MIO/MemRW/MIO_ready handshake.
// Optional bus error reporting: define MIO_ERR_EN to add the bus_err port.
`timescale 1ns/1ps
module mio_bus_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        CPU_MIO,
    input  logic        MemRW,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
`ifdef MIO_ERR_EN
    output logic        bus_err,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state, state_d;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic                req_err;
    logic                accept;
    logic                serve;
    logic [31:0]         mem [2**ADDR_W];

    // Low byte-offset bits and high alias bits only matter for error detection
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr_out[1:0], Addr_out[31:ADDR_W+2]};

`ifdef MIO_ERR_EN
    assign req_err = (Addr_out[1:0] != 2'b00) ||
                     (|(Addr_out >> (ADDR_W + 2)));
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        serve   = 1'b0;
        unique case (state)
            IDLE: begin
                if (CPU_MIO) begin
                    accept  = 1'b1;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) state_d = RESP;
            end
            RESP: begin
                serve   = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            MIO_ready <= 1'b0;
            Data_in   <= '0;
`ifdef MIO_ERR_EN
            bus_err   <= 1'b0;
`endif
        end else begin
            MIO_ready <= serve;
`ifdef MIO_ERR_EN
            bus_err   <= serve & err_q;
`endif
            if (accept) begin
                wr_q    <= MemRW;
                idx_q   <= Addr_out[ADDR_W+1:2];
                wdata_q <= Data_out;
                err_q   <= req_err;
                cnt     <= WAIT_INIT;
                busy    <= 1'b1;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == DONE) busy <= 1'b0;
            if (serve && !wr_q)
                Data_in <= err_q ? 32'hDEADBEEF : mem[idx_q];
        end
    end

    // RAM has no reset; an aborted transaction never reaches RESP
    always_ff @(posedge clk) begin
        if (serve && wr_q && !err_q) mem[idx_q] <= wdata_q;
    end

endmodule
